// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with a valid/ready handshake and a two-entry skid buffer.
// A bubble or flush forces the control bundle to BUBBLE_CTRL, and a saturating counter tracks stall cycles.
module pipe_stage_reg #(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 128,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // State bits are {out_valid, skid_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } state_t;

    state_t                 state_reg, state_next;
    logic [CTRL_W-1:0]      main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0]      main_data_reg, main_data_next;
    logic [CTRL_W-1:0]      skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0]      skid_data_reg, skid_data_next;
    logic [STALL_CNT_W-1:0] stall_reg, stall_next;
    logic                   accept;
    logic                   xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            main_ctrl_reg <= BUBBLE_CTRL;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
            stall_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
            stall_reg     <= stall_next;
        end
    end

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            // Flush drops both held beats and any beat accepted this cycle; data is left as is.
            state_next     = ST_EMPTY;
            main_ctrl_next = BUBBLE_CTRL;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next     = ST_FULL;
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end
                end
                ST_FULL: begin
                    if (xfer && accept) begin
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end else if (xfer) begin
                        state_next     = ST_EMPTY;
                        main_ctrl_next = BUBBLE_CTRL;
                    end else if (accept) begin
                        state_next     = ST_SKID;
                        skid_ctrl_next = in_ctrl;
                        skid_data_next = in_data;
                    end
                end
                ST_SKID: begin
                    if (xfer) begin
                        state_next     = ST_FULL;
                        main_ctrl_next = skid_ctrl_reg;
                        main_data_next = skid_data_reg;
                    end
                end
                default: begin
                    state_next     = ST_EMPTY;
                    main_ctrl_next = BUBBLE_CTRL;
                end
            endcase
        end
    end

    // The stall counter is independent of flush; it saturates instead of wrapping.
    always_comb begin
        stall_next = stall_reg;
        if (out_valid && !out_ready && (stall_reg != '1)) begin
            stall_next = stall_reg + 1'b1;
        end
    end

    always_comb begin
        out_valid    = (state_reg != ST_EMPTY);
        in_ready     = (state_reg != ST_SKID);
        out_ctrl     = main_ctrl_reg;
        out_data     = main_data_reg;
        stall_cycles = stall_reg;
    end

endmodule
